// File: rtl/cache_nway_ctrl.sv
// N-way set-associative, write-back, write-allocate data cache with true-LRU
// replacement and a miss FSM that writes back a dirty victim, then refills the line.
module cache_nway_ctrl #(
    parameter int WAYS       = 4,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              load,
    input  logic              edit,
    input  logic              inv,
    input  logic [2:0]        u_b_h_w,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic              hit,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int OFF_W  = BEAT_W + 2;
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {IDLE, WBACK, REFILL} state_t;

    state_t            state_q;
    logic [BEAT_W-1:0] beat_q;
    logic [WAY_W-1:0]  victim_q;
    logic              valid_q [WAYS][SETS];
    logic              dirty_q [WAYS][SETS];
    logic [WAY_W-1:0]  age_q   [WAYS][SETS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [31:0]       data_q  [WAYS][SETS][LINE_WORDS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    logic [BEAT_W-1:0] word_sel;
    logic [1:0]        byte_sel;

    assign idx      = addr[OFF_W +: IDX_W];
    assign req_tag  = addr[ADDR_W-1 -: TAG_W];
    assign word_sel = addr[2 +: BEAT_W];
    assign byte_sel = addr[1:0];

    logic             req, is_idle, hit_any, vic_found;
    logic             lookup_hit, lookup_miss, do_inv, last_beat;
    logic [WAY_W-1:0] hit_way, vic_way;

    // Requests are masked while rst is high so stall drops together with the FSM.
    assign req         = (load | edit) & ~rst;
    assign is_idle     = (state_q == IDLE);
    assign lookup_hit  = is_idle & req & hit_any;
    assign lookup_miss = is_idle & req & ~hit_any;
    assign do_inv      = is_idle & inv & ~(load | edit) & ~rst & hit_any;
    assign last_beat   = (beat_q == BEAT_W'(LINE_WORDS - 1));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        vic_found = 1'b0;
        vic_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_any && valid_q[w][idx] && tag_q[w][idx] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid_q[w][idx]) begin
                vic_found = 1'b1;
                vic_way   = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && age_q[w][idx] == WAY_W'(WAYS - 1)) begin
                vic_found = 1'b1;
                vic_way   = WAY_W'(w);
            end
        end
    end

    logic [31:0] rd_word, ld_val, wr_mask, wr_val, merged;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sgn;

    assign rd_word   = data_q[hit_way][idx][word_sel];
    assign byte_lane = rd_word[{byte_sel, 3'b000} +: 8];
    assign half_lane = rd_word[{byte_sel[1], 4'b0000} +: 16];
    assign sgn       = ~u_b_h_w[2];

    always_comb begin
        ld_val  = rd_word;
        wr_mask = '1;
        wr_val  = din;
        case (u_b_h_w[1:0])
            2'b00: begin
                ld_val  = {{24{sgn & byte_lane[7]}}, byte_lane};
                wr_mask = 32'h0000_00FF << {byte_sel, 3'b000};
                wr_val  = {4{din[7:0]}};
            end
            2'b01: begin
                ld_val  = {{16{sgn & half_lane[15]}}, half_lane};
                wr_mask = 32'h0000_FFFF << {byte_sel[1], 4'b0000};
                wr_val  = {2{din[15:0]}};
            end
            default: ;
        endcase
    end

    assign merged    = (rd_word & ~wr_mask) | (wr_val & wr_mask);
    assign hit       = lookup_hit;
    assign dout      = lookup_hit ? ld_val : '0;
    assign stall     = lookup_miss | ~is_idle;
    assign mem_req   = ~is_idle;
    assign mem_we    = (state_q == WBACK);
    assign mem_addr  = (state_q == WBACK)  ? {tag_q[victim_q][idx], idx, beat_q, 2'b00} :
                       (state_q == REFILL) ? {req_tag, idx, beat_q, 2'b00} : '0;
    assign mem_wdata = (state_q == WBACK) ? data_q[victim_q][idx][beat_q] : '0;

    // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            victim_q <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    age_q[w][s]   <= WAY_W'(w);
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (lookup_hit) begin
                        hit_cnt <= hit_cnt + 32'd1;
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == hit_way)
                                age_q[w][idx] <= '0;
                            else if (age_q[w][idx] < age_q[hit_way][idx])
                                age_q[w][idx] <= age_q[w][idx] + WAY_W'(1);
                        end
                        if (edit) dirty_q[hit_way][idx] <= 1'b1;
                    end else if (lookup_miss) begin
                        miss_cnt <= miss_cnt + 32'd1;
                        victim_q <= vic_way;
                        beat_q   <= '0;
                        state_q  <= (valid_q[vic_way][idx] && dirty_q[vic_way][idx]) ? WBACK : REFILL;
                    end else if (do_inv) begin
                        valid_q[hit_way][idx] <= 1'b0;
                        dirty_q[hit_way][idx] <= 1'b0;
                    end
                end
                WBACK: begin
                    if (mem_ack) begin
                        beat_q <= beat_q + BEAT_W'(1);
                        if (last_beat) state_q <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        beat_q <= beat_q + BEAT_W'(1);
                        if (last_beat) begin
                            valid_q[victim_q][idx] <= 1'b1;
                            dirty_q[victim_q][idx] <= 1'b0;
                            state_q                <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: tag/data arrays have no reset; cleared valid bits make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (lookup_hit && edit)
            data_q[hit_way][idx][word_sel] <= merged;
        if (state_q == REFILL && mem_ack) begin
            data_q[victim_q][idx][beat_q] <= mem_rdata;
            if (last_beat) tag_q[victim_q][idx] <= req_tag;
        end
    end
endmodule

// File: tb/tb_cache_nway_ctrl.sv
// Bench for cache_nway_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a recency-timestamp cache model and a word-addressed memory model.
module tb_cache_nway_ctrl;
    localparam int WAYS = 4;
    localparam int SETS = 16;
    localparam int LW   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        load = 1'b0, edit = 1'b0, inv = 1'b0;
    logic [2:0]  u_b_h_w = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        hit, stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    cache_nway_ctrl #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .addr(addr), .load(load), .edit(edit), .inv(inv),
        .u_b_h_w(u_b_h_w), .din(din), .dout(dout), .hit(hit), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Cache model: recency timestamps instead of ages; LRU = smallest stamp.
    bit          m_valid [WAYS][SETS];
    bit          m_dirty [WAYS][SETS];
    bit [23:0]   m_tag   [WAYS][SETS];
    bit [31:0]   m_data  [WAYS][SETS][LW];
    longint      m_stamp [WAYS][SETS];
    longint      now;
    int unsigned m_hits, m_misses;
    bit [31:0]   mem_q [int unsigned];

    bit        chk_en = 1'b0;
    bit        ack_always = 1'b1;
    bit        e_hit, e_stall, e_req, e_we;
    bit [31:0] e_dout, e_addr, e_wdata;
    bit [31:0] last_dout, wb1_data;
    int        stall_seen;
    int        n_checks = 0;
    int        n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("hit", hit, e_hit);
            check("stall", stall, e_stall);
            check("dout", dout, e_dout);
            check("mem_req", mem_req, e_req);
            if (e_req) begin
                check("mem_we", mem_we, e_we);
                check("mem_addr", mem_addr, e_addr);
                if (e_we) check("mem_wdata", mem_wdata, e_wdata);
            end
            check("hit_cnt", hit_cnt, m_hits);
            check("miss_cnt", miss_cnt, m_misses);
            if (stall) stall_seen++;
        end
    end

    function automatic bit [31:0] mem_rd(input bit [31:0] a);
        return mem_q.exists(a) ? mem_q[a] : (32'hA000_0000 | a);
    endfunction

    function automatic int find_way(input bit [31:0] a);
        int s = int'(a[7:4]);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[w][s] && m_tag[w][s] == a[31:8]) return w;
        return -1;
    endfunction

    function automatic int pick_victim(input int s);
        int v = 0;
        for (int w = 0; w < WAYS; w++) if (!m_valid[w][s]) return w;
        for (int w = 1; w < WAYS; w++) if (m_stamp[w][s] < m_stamp[v][s]) v = w;
        return v;
    endfunction

    function automatic bit [31:0] ext(input bit [31:0] word, input bit [31:0] a, input bit [2:0] sz);
        bit [7:0]  b;
        bit [15:0] h;
        case (sz[1:0])
            2'b00: begin
                b = word[8*int'(a[1:0]) +: 8];
                return sz[2] ? {24'h0, b} : {{24{b[7]}}, b};
            end
            2'b01: begin
                h = word[16*int'(a[1]) +: 16];
                return sz[2] ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: return word;
        endcase
    endfunction

    function automatic bit [31:0] merge(input bit [31:0] word, input bit [31:0] a,
                                        input bit [2:0] sz, input bit [31:0] d);
        bit [31:0] r = word;
        case (sz[1:0])
            2'b00:   r[8*int'(a[1:0]) +: 8] = d[7:0];
            2'b01:   r[16*int'(a[1]) +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
                m_stamp[w][s] = -longint'(w);
            end
        m_hits = 0;
        m_misses = 0;
        now = 0;
    endtask

    task automatic cycle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic set_quiet();
        e_hit = 1'b0; e_stall = 1'b0; e_dout = '0; e_req = 1'b0; e_we = 1'b0;
        e_addr = '0; e_wdata = '0;
    endtask

    // One memory beat; random ack holds are bounded to three cycles.
    task automatic beat(input bit we, input bit [31:0] a, input bit [31:0] wd);
        int waits = 0;
        bit ack;
        do begin
            ack = ack_always || (waits >= 3) || ($urandom_range(3) != 0);
            mem_ack = ack;
            mem_rdata = we ? $urandom : mem_rd(a);
            set_quiet();
            e_stall = 1'b1; e_req = 1'b1; e_we = we; e_addr = a; e_wdata = wd;
            cycle();
            waits++;
        end while (!ack);
        mem_ack = 1'b0;
    endtask

    task automatic access(input int op, input bit [31:0] a, input bit [2:0] sz, input bit [31:0] d);
        int s = int'(a[7:4]);
        int w, v;
        bit [31:0] old, la;
        addr = a; load = (op == 0); edit = (op == 1); inv = 1'b0;
        u_b_h_w = sz; din = d; mem_ack = 1'b0;
        stall_seen = 0;
        w = find_way(a);
        if (w < 0) begin
            set_quiet();
            e_stall = 1'b1;
            cycle();
            m_misses++;
            v = pick_victim(s);
            if (m_valid[v][s] && m_dirty[v][s]) begin
                for (int b = 0; b < LW; b++) begin
                    la = {m_tag[v][s], 4'(s), 2'(b), 2'b00};
                    if (b == 1) wb1_data = m_data[v][s][b];
                    beat(1'b1, la, m_data[v][s][b]);
                    mem_q[la] = m_data[v][s][b];
                end
            end
            for (int b = 0; b < LW; b++) begin
                la = {a[31:4], 2'(b), 2'b00};
                beat(1'b0, la, 32'h0);
                m_data[v][s][b] = mem_rd(la);
            end
            m_valid[v][s] = 1'b1;
            m_dirty[v][s] = 1'b0;
            m_tag[v][s]   = a[31:8];
            w = v;
        end
        old = m_data[w][s][a[3:2]];
        set_quiet();
        e_hit = 1'b1;
        e_dout = ext(old, a, sz);
        last_dout = e_dout;
        cycle();
        m_hits++;
        now++;
        m_stamp[w][s] = now;
        if (op == 1) begin
            m_data[w][s][a[3:2]] = merge(old, a, sz, d);
            m_dirty[w][s] = 1'b1;
        end
    endtask

    task automatic inv_op(input bit [31:0] a);
        int w;
        addr = a; load = 1'b0; edit = 1'b0; inv = 1'b1; mem_ack = 1'b0;
        set_quiet();
        cycle();
        w = find_way(a);
        if (w >= 0) begin
            m_valid[w][int'(a[7:4])] = 1'b0;
            m_dirty[w][int'(a[7:4])] = 1'b0;
        end
        inv = 1'b0;
    endtask

    task automatic idle_op();
        load = 1'b0; edit = 1'b0; inv = 1'b0; mem_ack = 1'b0;
        set_quiet();
        cycle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int op;
        bit [31:0] a, tagv;
        model_reset();
        set_quiet();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hit", hit, 0);
        check("rst_stall", stall, 0);
        check("rst_dout", dout, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Cold miss, clean refill.
        access(0, 32'h004, 3'b010, 0);
        check("cold_stall_cycles", stall_seen, 5);
        check("cold_dout_model", last_dout, 32'hA000_0004);
        check("cold_miss_cnt", miss_cnt, 1);
        check("cold_hit_cnt", hit_cnt, 1);

        // Byte store and sign/zero-extended loads.
        access(1, 32'h005, 3'b000, 32'hEF);
        check("edit_stall_cycles", stall_seen, 0);
        access(0, 32'h004, 3'b010, 0);
        check("edit_word_model", last_dout, 32'hA000_EF04);
        access(0, 32'h005, 3'b000, 0);
        check("byte_signed_model", last_dout, 32'hFFFF_FFEF);
        access(0, 32'h005, 3'b100, 0);
        check("byte_unsigned_model", last_dout, 32'h0000_00EF);

        // Fill set 0 and evict the LRU way.
        access(0, 32'h104, 3'b010, 0);
        access(0, 32'h204, 3'b010, 0);
        access(0, 32'h304, 3'b010, 0);
        access(0, 32'h004, 3'b010, 0);
        check("reload_hit_cycles", stall_seen, 0);
        access(0, 32'h404, 3'b010, 0);
        access(0, 32'h004, 3'b010, 0);
        check("survivor_hit_cycles", stall_seen, 0);
        access(0, 32'h104, 3'b010, 0);
        check("evicted_miss_cycles", stall_seen, 5);

        // Make the dirty 0x004 line LRU, then force its write-back.
        access(0, 32'h404, 3'b010, 0);
        access(0, 32'h304, 3'b010, 0);
        access(0, 32'h104, 3'b010, 0);
        access(0, 32'h504, 3'b010, 0);
        check("dirty_miss_cycles", stall_seen, 9);
        check("wb_beat1_model", wb1_data, 32'hA000_EF04);

        // Reset in the middle of a stalled refill.
        chk_en = 1'b0;
        addr = 32'h604; load = 1'b1; edit = 1'b0; inv = 1'b0; u_b_h_w = 3'b010; mem_ack = 1'b0;
        cycle();
        cycle();
        check("refill_req", mem_req, 1);
        check("refill_we", mem_we, 0);
        check("refill_stall", stall, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_mem_req", mem_req, 0);
        check("midrst_stall", stall, 0);
        @(negedge clk);
        load = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("post_rst_hit_cnt", hit_cnt, 0);
        check("post_rst_miss_cnt", miss_cnt, 0);
        chk_en = 1'b1;
        access(0, 32'h004, 3'b010, 0);
        check("post_rst_miss_cycles", stall_seen, 5);
        check("post_rst_dout_model", last_dout, 32'hA000_EF04);

        // Invalidate and re-miss.
        access(0, 32'h104, 3'b010, 0);
        access(0, 32'h004, 3'b010, 0);
        inv_op(32'h004);
        access(0, 32'h104, 3'b010, 0);
        check("inv_other_hit_cycles", stall_seen, 0);
        access(0, 32'h004, 3'b010, 0);
        check("inv_remiss_cycles", stall_seen, 5);

        // Random traffic over a few tags in two sets, with random ack holds.
        ack_always = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tagv = $urandom_range(5);
            tagv = (tagv * 32'h0001_0101) & 32'h00FF_FFFF;
            a = (tagv << 8) | ($urandom_range(1) << 4) | $urandom_range(15);
            op = $urandom_range(9);
            if (op <= 4)      access(0, a, 3'($urandom_range(7)), 0);
            else if (op <= 7) access(1, a, 3'($urandom_range(7)), $urandom);
            else if (op == 8) inv_op(a);
            else              idle_op();
        end
        idle_op();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
